// File: rtl/cl_crc_stream.sv
// Purpose  : inline streaming CRC engine; APPEND adds CRC trailer beats, CHECK verifies residue.
// Latency  : 1 cycle input-to-output through a single output register.
// Backpress: s_ready drops while the output register is stalled or trailer beats are being emitted.
//
// Ports: clk/rst_n (async active-low); mode (0=APPEND, 1=CHECK, sampled on first beat);
//        s_valid/s_ready/s_data/s_keep/s_last input stream; m_valid/m_ready/m_data/m_keep/m_last
//        output stream; crc_value/crc_done/crc_err report the final CRC of each frame.
// Optional: define CL_CRC_STREAM_STATS_EN to add saturating frame_cnt/err_cnt outputs.
module cl_crc_stream #(
  parameter int          DATA_W  = 32,
  parameter int          CRC_W   = 32,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
  parameter int          REFLECT = 1,
  parameter logic [31:0] RESIDUE = 32'h2144DF1C
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATA_W-1:0]   m_data,
  output logic [DATA_W/8-1:0] m_keep,
  output logic                m_last,
  output logic [CRC_W-1:0]    crc_value,
  output logic                crc_done,
  output logic                crc_err
`ifdef CL_CRC_STREAM_STATS_EN
  ,
  output logic [31:0]         frame_cnt,
  output logic [31:0]         err_cnt
`endif
);

  localparam int NB  = DATA_W / 8;
  localparam int CB  = CRC_W / 8;
  localparam int NT  = (CRC_W + DATA_W - 1) / DATA_W;
  localparam int TW  = NT * DATA_W;
  localparam int TCW = (NT > 1) ? $clog2(NT) : 1;
  localparam int REM = CB % NB;

  localparam logic [CRC_W-1:0] POLY_C = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_C = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_C  = XOR_OUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] RES_C  = RESIDUE[CRC_W-1:0];

  localparam logic [NB-1:0] KEEP_FULL = '1;
  // Last trailer beat only carries the CRC bytes left over after full beats.
  localparam logic [NB-1:0] KEEP_LAST = (REM == 0) ? KEEP_FULL : (KEEP_FULL >> (NB - REM));

  typedef enum logic [1:0] {IDLE, DATA, TRAILER} state_t;

  state_t           state;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] final_q;
  logic             mode_q;
  logic [TCW-1:0]   tcnt;

  logic             load_ok;
  logic             acc;
  logic             eff_mode;
  logic             last_trl;
  logic [CRC_W-1:0] crc_next;
  logic [CRC_W-1:0] fin_next;
  logic [TW-1:0]    trl_vec;
  logic [DATA_W-1:0] trl_beat;
  logic             done_evt;
  logic             err_evt;

  // One byte through a bit-serial MSB-first update. Reflected CRCs are handled by
  // reversing the input byte here and the register at finalisation.
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c, input logic [7:0] b);
    logic [CRC_W-1:0] r;
    logic [7:0]       d;
    logic             fb;
    r = c;
    d = b;
    if (REFLECT != 0) begin
      for (int i = 0; i < 8; i++) d[i] = b[7-i];
    end
    for (int i = 7; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = r << 1;
      if (fb) r = r ^ POLY_C;
    end
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] crc_fin(input logic [CRC_W-1:0] r);
    logic [CRC_W-1:0] o;
    o = r;
    if (REFLECT != 0) begin
      for (int i = 0; i < CRC_W; i++) o[i] = r[CRC_W-1-i];
    end
    return o ^ XOR_C;
  endfunction

  assign load_ok  = !m_valid || m_ready;
  assign s_ready  = (state != TRAILER) && load_ok;
  assign acc      = s_valid && s_ready;
  // Mode is captured on the first beat; later changes inside the frame are ignored.
  assign eff_mode = (state == IDLE) ? mode : mode_q;
  assign last_trl = (tcnt == TCW'(NT - 1));

  // Unrolled per-byte update over enabled bytes only, byte 0 first.
  always_comb begin
    crc_next = (state == IDLE) ? INIT_C : crc_q;
    for (int k = 0; k < NB; k++) begin
      if (s_keep[k]) crc_next = crc_byte(crc_next, s_data[8*k +: 8]);
    end
    fin_next = crc_fin(crc_next);
  end

  always_comb begin
    trl_vec = '0;
    trl_vec[CRC_W-1:0] = final_q;
    trl_beat = trl_vec[int'(tcnt)*DATA_W +: DATA_W];
  end

  assign done_evt = (acc && s_last && eff_mode) ||
                    ((state == TRAILER) && load_ok && (tcnt == '0));
  assign err_evt  = acc && s_last && eff_mode && (fin_next != RES_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      crc_q     <= INIT_C;
      final_q   <= '0;
      mode_q    <= 1'b0;
      tcnt      <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_keep    <= '0;
      m_last    <= 1'b0;
      crc_value <= '0;
      crc_done  <= 1'b0;
      crc_err   <= 1'b0;
    end else begin
      crc_done <= done_evt;
      crc_err  <= err_evt;
      if (m_valid && m_ready) m_valid <= 1'b0;
      case (state)
        IDLE, DATA: begin
          if (acc) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_keep  <= s_keep;
            if (state == IDLE) mode_q <= mode;
            if (s_last) begin
              crc_q <= INIT_C;
              if (eff_mode) begin
                m_last    <= 1'b1;
                crc_value <= fin_next;
                state     <= IDLE;
              end else begin
                // Trailer always starts a fresh beat, never merged into this one.
                m_last  <= 1'b0;
                final_q <= fin_next;
                tcnt    <= '0;
                state   <= TRAILER;
              end
            end else begin
              m_last <= 1'b0;
              crc_q  <= crc_next;
              state  <= DATA;
            end
          end
        end
        TRAILER: begin
          if (load_ok) begin
            m_valid <= 1'b1;
            m_data  <= trl_beat;
            m_keep  <= last_trl ? KEEP_LAST : KEEP_FULL;
            m_last  <= last_trl;
            if (tcnt == '0) crc_value <= final_q;
            if (last_trl) begin
              // Leaving as the last trailer beat loads lets the next frame start next cycle.
              tcnt  <= '0;
              state <= IDLE;
            end else begin
              tcnt <= tcnt + TCW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CL_CRC_STREAM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (done_evt && (frame_cnt != 32'hFFFFFFFF)) frame_cnt <= frame_cnt + 32'd1;
      if (err_evt && (err_cnt != 32'hFFFFFFFF)) err_cnt <= err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cl_crc_stream.sv
// Purpose  : directed scoreboard bench for cl_crc_stream in three parameter sets.
// Latency  : expected beats/CRC results are queued at issue, popped by monitors on transfer.
// Backpress: exercises m_ready toggling and checks output hold while stalled.
module tb_cl_crc_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // u0: defaults (CRC-32, 32-bit datapath)
  logic        mode0, s_valid0, s_ready0, s_last0, m_valid0, m_ready0, m_last0, crc_done0, crc_err0;
  logic [31:0] s_data0, m_data0, crc_value0;
  logic [3:0]  s_keep0, m_keep0;
  // u1: CRC-16/CCITT-FALSE, 8-bit datapath
  logic        mode1, s_valid1, s_ready1, s_last1, m_valid1, m_ready1, m_last1, crc_done1, crc_err1;
  logic [7:0]  s_data1, m_data1;
  logic [0:0]  s_keep1, m_keep1;
  logic [15:0] crc_value1;
  // u2: CRC-8 poly 07, 8-bit datapath
  logic        mode2, s_valid2, s_ready2, s_last2, m_valid2, m_ready2, m_last2, crc_done2, crc_err2;
  logic [7:0]  s_data2, m_data2, crc_value2;
  logic [0:0]  s_keep2, m_keep2;

  cl_crc_stream u0 (
    .clk(clk), .rst_n(rst_n), .mode(mode0), .s_valid(s_valid0), .s_ready(s_ready0),
    .s_data(s_data0), .s_keep(s_keep0), .s_last(s_last0), .m_valid(m_valid0), .m_ready(m_ready0),
    .m_data(m_data0), .m_keep(m_keep0), .m_last(m_last0), .crc_value(crc_value0),
    .crc_done(crc_done0), .crc_err(crc_err0));

  cl_crc_stream #(.DATA_W(8), .CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF), .XOR_OUT(32'h0),
                  .REFLECT(0), .RESIDUE(32'h0)) u1 (
    .clk(clk), .rst_n(rst_n), .mode(mode1), .s_valid(s_valid1), .s_ready(s_ready1),
    .s_data(s_data1), .s_keep(s_keep1), .s_last(s_last1), .m_valid(m_valid1), .m_ready(m_ready1),
    .m_data(m_data1), .m_keep(m_keep1), .m_last(m_last1), .crc_value(crc_value1),
    .crc_done(crc_done1), .crc_err(crc_err1));

  cl_crc_stream #(.DATA_W(8), .CRC_W(8), .POLY(32'h07), .INIT(32'h0), .XOR_OUT(32'h0),
                  .REFLECT(0), .RESIDUE(32'h0)) u2 (
    .clk(clk), .rst_n(rst_n), .mode(mode2), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_data(s_data2), .s_keep(s_keep2), .s_last(s_last2), .m_valid(m_valid2), .m_ready(m_ready2),
    .m_data(m_data2), .m_keep(m_keep2), .m_last(m_last2), .crc_value(crc_value2),
    .crc_done(crc_done2), .crc_err(crc_err2));

  typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
  typedef struct packed { logic [31:0] v; logic e; logic vchk; } crc_t;

  beat_t qb0[$], qb1[$], qb2[$];
  crc_t  qc0[$], qc1[$], qc2[$];

  int checks = 0;
  int failures = 0;
  logic tog0 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    return b;
  endfunction

  function automatic crc_t mkc(input logic [31:0] v, input logic e, input logic vchk);
    crc_t c;
    c.v = v; c.e = e; c.vchk = vchk;
    return c;
  endfunction

  task automatic push_beat(input int id, input beat_t b);
    case (id)
      0: qb0.push_back(b);
      1: qb1.push_back(b);
      default: qb2.push_back(b);
    endcase
  endtask

  task automatic push_crc(input int id, input crc_t c);
    case (id)
      0: qc0.push_back(c);
      1: qc1.push_back(c);
      default: qc2.push_back(c);
    endcase
  endtask

  task automatic pop_beat(input int id, input beat_t act);
    beat_t e;
    int    n;
    n = (id == 0) ? qb0.size() : (id == 1) ? qb1.size() : qb2.size();
    if (n == 0) begin
      checks++; failures++;
      $display("FAIL beat%0d unexpected: got %h expected none", id, act);
    end else begin
      case (id)
        0: e = qb0.pop_front();
        1: e = qb1.pop_front();
        default: e = qb2.pop_front();
      endcase
      check($sformatf("beat%0d", id), 64'(act), 64'(e));
    end
  endtask

  task automatic pop_crc(input int id, input logic [31:0] v, input logic err);
    crc_t e;
    int   n;
    n = (id == 0) ? qc0.size() : (id == 1) ? qc1.size() : qc2.size();
    if (n == 0) begin
      checks++; failures++;
      $display("FAIL crc_done%0d unexpected: got value %h err %0b expected none", id, v, err);
    end else begin
      case (id)
        0: e = qc0.pop_front();
        1: e = qc1.pop_front();
        default: e = qc2.pop_front();
      endcase
      check($sformatf("crc_err%0d", id), 64'(err), 64'(e.e));
      if (e.vchk) check($sformatf("crc_value%0d", id), 64'(v), 64'(e.v));
    end
  endtask

  // Monitors: sample at negedge; a beat transfers at the next posedge when valid && ready.
  logic  st0 = 1'b0;
  beat_t held0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (m_valid0 && m_ready0) pop_beat(0, {m_data0, m_keep0, m_last0});
        if (m_valid1 && m_ready1) pop_beat(1, {24'h0, m_data1, 3'b0, m_keep1, m_last1});
        if (m_valid2 && m_ready2) pop_beat(2, {24'h0, m_data2, 3'b0, m_keep2, m_last2});
        if (crc_done0) pop_crc(0, crc_value0, crc_err0);
        if (crc_done1) pop_crc(1, {16'h0, crc_value1}, crc_err1);
        if (crc_done2) pop_crc(2, {24'h0, crc_value2}, crc_err2);
        if (st0) check("stall_hold0", 64'({m_valid0, m_data0, m_keep0, m_last0}), 64'({1'b1, held0}));
        st0   = m_valid0 && !m_ready0;
        held0 = {m_data0, m_keep0, m_last0};
      end else begin
        st0 = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog0) m_ready0 = ~m_ready0;
    end
  end

  // Drive one beat at posedge+1 and hold it until accepted; valid stays high afterwards.
  task automatic send0(input logic [31:0] d, input logic [3:0] k, input logic l, input logic md);
    int waits;
    waits = 0;
    s_valid0 = 1'b1; s_data0 = d; s_keep0 = k; s_last0 = l; mode0 = md;
    push_beat(0, mk(d, k, l && md));
    while (1) begin
      @(negedge clk);
      if (s_ready0 || waits > 200) break;
      waits++;
      @(posedge clk); #1;
    end
    if (waits > 200) begin
      checks++; failures++;
      $display("FAIL send0 timeout: got no s_ready required s_ready within 200 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic send8(input int id, input logic [7:0] d, input logic l, input logic md,
                       output int waits);
    logic rdy;
    waits = 0;
    if (id == 1) begin
      s_valid1 = 1'b1; s_data1 = d; s_keep1 = 1'b1; s_last1 = l; mode1 = md;
    end else begin
      s_valid2 = 1'b1; s_data2 = d; s_keep2 = 1'b1; s_last2 = l; mode2 = md;
    end
    push_beat(id, mk({24'h0, d}, 4'b0001, l && md));
    while (1) begin
      @(negedge clk);
      rdy = (id == 1) ? s_ready1 : s_ready2;
      if (rdy || waits > 200) break;
      waits++;
      @(posedge clk); #1;
    end
    if (waits > 200) begin
      checks++; failures++;
      $display("FAIL send8 u%0d timeout: got no s_ready required s_ready within 200 cycles", id);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    s_valid0 = 1'b0; s_valid1 = 1'b0; s_valid2 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qb0.size() + qb1.size() + qb2.size() + qc0.size() + qc1.size() + qc2.size()) != 0
           && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL drain timeout: got %0d pending required 0",
               qb0.size() + qb1.size() + qb2.size() + qc0.size() + qc1.size() + qc2.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic append_123456789_u0();
    send0(32'h34333231, 4'hF, 1'b0, 1'b0);
    send0(32'h38373635, 4'hF, 1'b0, 1'b0);
    push_crc(0, mkc(32'hCBF43926, 1'b0, 1'b1));
    send0(32'h00000039, 4'h1, 1'b1, 1'b0);
    push_beat(0, mk(32'hCBF43926, 4'hF, 1'b1));
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    s_valid0 = 0; s_data0 = '0; s_keep0 = '0; s_last0 = 0; mode0 = 0; m_ready0 = 1;
    s_valid1 = 0; s_data1 = '0; s_keep1 = '0; s_last1 = 0; mode1 = 0; m_ready1 = 1;
    s_valid2 = 0; s_data2 = '0; s_keep2 = '0; s_last2 = 0; mode2 = 0; m_ready2 = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs0", 64'({m_valid0, m_data0, m_keep0, m_last0, crc_value0, crc_done0, crc_err0}), 64'h0);
    check("rst_outputs1", 64'({m_valid1, m_data1, m_keep1, m_last1, crc_value1, crc_done1, crc_err1}), 64'h0);
    check("rst_outputs2", 64'({m_valid2, m_data2, m_keep2, m_last2, crc_value2, crc_done2, crc_err2}), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // APPEND CRC-32 "123456789" -> trailer CBF43926
    append_123456789_u0();
    idle_all();
    drain();

    // CHECK with correct CRC appended -> residue matches
    push_crc(0, mkc(32'h2144DF1C, 1'b0, 1'b1));
    send0(32'h34333231, 4'hF, 1'b0, 1'b1);
    send0(32'h38373635, 4'hF, 1'b0, 1'b0);
    send0(32'hF4392639, 4'hF, 1'b0, 1'b0);
    send0(32'h000000CB, 4'h1, 1'b1, 1'b1);
    idle_all();
    drain();

    // CHECK with one payload bit flipped -> crc_err
    push_crc(0, mkc(32'h0, 1'b1, 1'b0));
    send0(32'h34333230, 4'hF, 1'b0, 1'b1);
    send0(32'h38373635, 4'hF, 1'b0, 1'b1);
    send0(32'hF4392639, 4'hF, 1'b0, 1'b1);
    send0(32'h000000CB, 4'h1, 1'b1, 1'b1);
    idle_all();
    drain();

    // Backpressure: m_ready toggles every cycle, s_valid held across the frame
    tog0 = 1'b1;
    append_123456789_u0();
    idle_all();
    drain();
    tog0 = 1'b0;
    m_ready0 = 1'b1;

    // CRC-16/CCITT-FALSE on 8-bit datapath -> 29B1, two trailer beats LS byte first
    for (int i = 0; i < 8; i++) send8(1, 8'h31 + 8'(i), 1'b0, 1'b0, w);
    push_crc(1, mkc(32'h29B1, 1'b0, 1'b1));
    send8(1, 8'h39, 1'b1, 1'b0, w);
    push_beat(1, mk(32'hB1, 4'b0001, 1'b0));
    push_beat(1, mk(32'h29, 4'b0001, 1'b1));
    idle_all();
    drain();

    // Back-to-back single-beat CHECK frames on CRC-8 -> 97 and err every frame, no gap
    for (int f = 0; f < 3; f++) begin
      push_crc(2, mkc(32'h97, 1'b1, 1'b1));
      send8(2, 8'h31, 1'b1, 1'b1, w);
      check($sformatf("b2b_wait_cycles_f%0d", f), 64'(w), 64'h0);
    end
    idle_all();
    drain();

    // Reset in the middle of a frame: outputs clear at once, next frame is clean
    send0(32'h34333231, 4'hF, 1'b0, 1'b0);
    send0(32'h38373635, 4'hF, 1'b0, 1'b0);
    idle_all();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs0", 64'({m_valid0, m_data0, m_keep0, m_last0, crc_value0, crc_done0, crc_err0}), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    append_123456789_u0();
    idle_all();
    drain();

    check("leftover_beats", 64'(qb0.size() + qb1.size() + qb2.size()), 64'h0);
    check("leftover_crcs", 64'(qc0.size() + qc1.size() + qc2.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
